ram_sync_ctrl: RTL and testbench
================================

// Module: ram_sync_ctrl
// PURPOSE
//   Parametrised single-port synchronous RAM with a valid/ready request port,
//   a pipelined read response and a built-in zero-fill (clear) sequencer.
//   Successor to the fixed 8-bit x 64-word RAM. Generalised in width, depth,
//   read latency and fill value. Adds request handshaking and hardware init.
//   Sits between a request source (address/data/we generator) and consumers.
// PARAMETERS
//   DATA_W     8   data word width, bits
//   ADDR_W     6   address width; depth = 2**ADDR_W words
//   READ_LAT   1   read latency in cycles, legal values 1 or 2
//   CLEAR_VAL  0   DATA_W-bit value written to every word by the clear sweep
// PORTS
//   clk        in   1        single clock, all state on rising edge
//   rst        in   1        asynchronous reset, active-high
//   clear      in   1        one-cycle pulse: start clear sweep (ignored while busy)
//   req_valid  in   1        request present
//   req_ready  out  1        request accepted when req_valid & req_ready at clk edge
//   req_we     in   1        1 = write, 0 = read
//   req_addr   in   ADDR_W   word address
//   req_data   in   DATA_W   write data
//   rsp_valid  out  1        read data valid, exactly one cycle per accepted read
//   rsp_data   out  DATA_W   read data; holds last value when rsp_valid = 0
//   busy       out  1        clear sweep in progress
// BEHAVIOUR
//   - Reset values: state = CLEAR, clr_addr = 0, busy = 1, req_ready = 0,
//     rsp_valid = 0, rsp_data = 0, read pipeline valid bits = 0.
//     Array contents are not reset; the sweep initialises them.
//   - FSM states:
//     - CLEAR: each cycle writes CLEAR_VAL to mem[clr_addr] and increments clr_addr.
//       At clr_addr = 2**ADDR_W-1, writes the last word and goes to IDLE.
//       Sweep takes exactly 2**ADDR_W cycles.
//     - IDLE: serves requests. clear = 1 -> CLEAR with clr_addr = 0 on next edge.
//   - busy = (state == CLEAR).
//   - req_ready = (state == IDLE) & ~clear. This is combinational.
//     When clear and req_valid occur in the same cycle, clear wins and the request is not taken.
//   - Throughput: one request per cycle, no bubbles between back-to-back requests.
//   - Write: mem[req_addr] <= req_data on the accepting edge. No response is generated.
//   - Read: data sampled from the array on the accepting edge.
//     rsp_valid pulses READ_LAT cycles after acceptance.
//     With READ_LAT = 1, rsp_valid is high in the cycle after the accept edge.
//     A read that follows a write to the same address on a later cycle returns the new data.
//   - No response backpressure. The consumer must sink every rsp_valid pulse.
//   - Reads accepted before a clear deliver their pre-clear data normally;
//     the pipeline is not flushed by clear.
//   - clear asserted while busy: ignored, and the sweep does not restart.
//   - rst asserted mid-sweep or mid-read: immediate return to reset values.
//     In-flight responses are dropped. After release, a full sweep restarts from address 0.
//   - Address wrap: clr_addr is ADDR_W+0 bits wide and detected at all-ones, with no overflow read.
//   - READ_LAT values other than 1 or 2 are illegal.
//     Simulation must report an error at elaboration via an initial check.
// TESTING (DATA_W=8, ADDR_W=6, READ_LAT=1 unless noted)
//   1. Release rst -> busy = 1 for exactly 64 cycles, req_ready = 0 throughout.
//      Then a read of 0x3F -> rsp_data = 0x00 one cycle after accept.
//   2. Write 0xA5 @0x12, then read @0x12 on the next cycle.
//      -> rsp_valid 1 cycle after the read accept, rsp_data = 0xA5.
//      No rsp_valid pulse is produced for the write.
//   3. Back-to-back reads @0x00..0x07 after writing data = addr+0x10 to each.
//      -> 8 consecutive rsp_valid cycles with data 0x10..0x17 in order.
//   4. Pulse clear with req_valid = 1 in the same cycle -> request not accepted,
//      busy for 64 cycles, all words then read back as CLEAR_VAL.
//      A read accepted the cycle before clear returns old data.
//   5. Assert rst when clr_addr = 30 -> all outputs at reset values immediately.
//      After release, a full 64-cycle sweep runs from address 0.
//   6. READ_LAT=2: write 0x3C @0x05, read @0x05 -> rsp_valid exactly 2 cycles after accept,
//      data 0x3C. Assert rst with a read in flight -> no rsp_valid pulse emerges.

Source files
------------

// File: rtl/ram_sync_ctrl_if.sv
// ram_sync_ctrl_if: request/response bundle between a request source and ram_sync_ctrl
//   clear      master->slave  one-cycle pulse starting a clear sweep
//   req_valid  master->slave  request present
//   req_ready  slave->master  request accepted when valid & ready at clk edge
//   req_we     master->slave  1 = write, 0 = read
//   req_addr   master->slave  word address
//   req_data   master->slave  write data
//   rsp_valid  slave->master  read data valid, one cycle per accepted read
//   rsp_data   slave->master  read data, held while rsp_valid = 0
//   busy       slave->master  clear sweep in progress
interface ram_sync_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
);
   logic              clear;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              busy;
   modport master (
      output clear, req_valid, req_we, req_addr, req_data,
      input  req_ready, rsp_valid, rsp_data, busy
   );
   modport slave (
      input  clear, req_valid, req_we, req_addr, req_data,
      output req_ready, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/ram_sync_ctrl.sv
// ram_sync_ctrl: single-port synchronous RAM with valid/ready requests, pipelined reads and a clear sweep
//   clk  in     rising-edge clock for all state
//   rst  in     asynchronous active-high reset; restarts the clear sweep from address 0
//   bus  slave  request/response bundle (see ram_sync_ctrl_if)
module ram_sync_ctrl #(
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = 6,
   parameter int                READ_LAT  = 1,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input logic            clk,
   input logic            rst,
   ram_sync_ctrl_if.slave bus
);
   if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $error("ram_sync_ctrl: READ_LAT must be 1 or 2");
   end
   typedef enum logic {CLEAR, IDLE} state_t;
   state_t            state;
   logic [ADDR_W-1:0] clr_addr;
   logic              busy_q;
   logic [1:0]        vld;
   logic [DATA_W-1:0] pipe;
   logic [DATA_W-1:0] rsp_q;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic              ready;
   logic              acc;
   logic              rd_acc;
   // clear takes priority over a request presented in the same cycle
   assign ready         = (state == IDLE) & ~bus.clear;
   assign acc           = bus.req_valid & ready;
   assign rd_acc        = acc & ~bus.req_we;
   assign bus.req_ready = ready;
   assign bus.busy      = busy_q;
   assign bus.rsp_valid = (READ_LAT == 1) ? vld[0] : vld[1];
   assign bus.rsp_data  = rsp_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CLEAR;
         clr_addr <= '0;
         busy_q   <= 1'b1;
         vld      <= '0;
         pipe     <= '0;
         rsp_q    <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == '1) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               if (bus.clear) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
                  busy_q   <= 1'b1;
               end
            end
         endcase
         // the read pipeline keeps running through a clear; in-flight reads complete
         vld <= {vld[0], rd_acc};
         if (rd_acc) pipe <= mem[bus.req_addr];
         if (READ_LAT == 1) begin
            if (rd_acc) rsp_q <= mem[bus.req_addr];
         end else if (vld[0]) begin
            rsp_q <= pipe;
         end
      end
   end
   // array is deliberately left unreset; the sweep initialises it
   always_ff @(posedge clk) begin
      if (busy_q) mem[clr_addr] <= CLEAR_VAL;
      else if (acc && bus.req_we) mem[bus.req_addr] <= bus.req_data;
   end
endmodule

// File: tb/tb_ram_sync_ctrl.sv
// tb_ram_sync_ctrl: directed bench for ram_sync_ctrl at READ_LAT 1 and 2
module tb_ram_sync_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic rst2;
   int   checks = 0;
   int   fails  = 0;
   always #5 clk = ~clk;
   ram_sync_ctrl_if #(.DATA_W(8), .ADDR_W(6)) b1 ();
   ram_sync_ctrl_if #(.DATA_W(8), .ADDR_W(6)) b2 ();
   ram_sync_ctrl #(.DATA_W(8), .ADDR_W(6), .READ_LAT(1), .CLEAR_VAL(8'h00)) dut1 (
      .clk(clk), .rst(rst), .bus(b1)
   );
   ram_sync_ctrl #(.DATA_W(8), .ADDR_W(6), .READ_LAT(2), .CLEAR_VAL(8'h5A)) dut2 (
      .clk(clk), .rst(rst2), .bus(b2)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      int n;
      bit bad;
      rst = 1'b1;
      #2;
      checks++; if (b1.busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %0b want 1", b1.busy); end
      checks++; if (b1.req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %0b want 0", b1.req_ready); end
      checks++; if (b1.rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %0b want 0", b1.rsp_valid); end
      checks++; if (b1.rsp_data !== 8'h00) begin fails++; $display("FAIL rst_rsp_data: got %h want 00", b1.rsp_data); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n = 0;
      bad = 1'b0;
      while (b1.busy && n < 200) begin
         if (b1.req_ready !== 1'b0) bad = 1'b1;
         tick;
         n++;
      end
      checks++; if (n != 64) begin fails++; $display("FAIL sweep_len: got %0d cycles want 64", n); end
      checks++; if (bad) begin fails++; $display("FAIL sweep_ready: got ready=1 during sweep want 0"); end
      b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 6'h3F;
      #1;
      checks++; if (b1.req_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %0b want 1", b1.req_ready); end
      tick;
      b1.req_valid = 1'b0;
      checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 8'h00) begin fails++; $display("FAIL read_3f: got v=%0b d=%h want v=1 d=00", b1.rsp_valid, b1.rsp_data); end
      tick;
      checks++; if (b1.rsp_valid !== 1'b0) begin fails++; $display("FAIL read_3f_pulse: got v=%0b want 0", b1.rsp_valid); end
   endtask
   task automatic test_write_read;
      b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 6'h12; b1.req_data = 8'hA5;
      tick;
      b1.req_we = 1'b0;
      checks++; if (b1.rsp_valid !== 1'b0) begin fails++; $display("FAIL write_no_rsp: got v=%0b want 0", b1.rsp_valid); end
      tick;
      b1.req_valid = 1'b0;
      checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 8'hA5) begin fails++; $display("FAIL wr_rd_12: got v=%0b d=%h want v=1 d=a5", b1.rsp_valid, b1.rsp_data); end
      tick;
      checks++; if (b1.rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rd_pulse: got v=%0b want 0", b1.rsp_valid); end
   endtask
   task automatic test_back_to_back;
      b1.req_valid = 1'b1; b1.req_we = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b1.req_addr = 6'(i); b1.req_data = 8'(8'h10 + i);
         tick;
      end
      b1.req_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b1.req_addr = 6'(i);
         tick;
         checks++;
         if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 8'(8'h10 + i)) begin
            fails++; $display("FAIL b2b_%0d: got v=%0b d=%h want v=1 d=%h", i, b1.rsp_valid, b1.rsp_data, 8'(8'h10 + i));
         end
      end
      b1.req_valid = 1'b0;
      tick;
      checks++; if (b1.rsp_valid !== 1'b0 || b1.rsp_data !== 8'h17) begin fails++; $display("FAIL b2b_hold: got v=%0b d=%h want v=0 d=17", b1.rsp_valid, b1.rsp_data); end
   endtask
   task automatic test_clear;
      int n;
      b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 6'h20; b1.req_data = 8'h77;
      tick;
      b1.req_we = 1'b0;
      tick;
      b1.clear = 1'b1; b1.req_addr = 6'h21;
      #1;
      checks++; if (b1.req_ready !== 1'b0) begin fails++; $display("FAIL clear_wins: got ready=%0b want 0", b1.req_ready); end
      checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 8'h77) begin fails++; $display("FAIL pre_clear_read: got v=%0b d=%h want v=1 d=77", b1.rsp_valid, b1.rsp_data); end
      tick;
      b1.clear = 1'b0; b1.req_valid = 1'b0;
      checks++; if (b1.busy !== 1'b1 || b1.rsp_valid !== 1'b0) begin fails++; $display("FAIL clear_start: got busy=%0b v=%0b want busy=1 v=0", b1.busy, b1.rsp_valid); end
      n = 0;
      while (b1.busy && n < 200) begin
         b1.clear = (n == 10);
         tick;
         n++;
      end
      b1.clear = 1'b0;
      checks++; if (n != 64) begin fails++; $display("FAIL clear_len: got %0d cycles want 64", n); end
      b1.req_valid = 1'b1; b1.req_we = 1'b0;
      for (int i = 0; i < 64; i++) begin
         b1.req_addr = 6'(i);
         tick;
         checks++;
         if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 8'h00) begin
            fails++; $display("FAIL cleared_%0d: got v=%0b d=%h want v=1 d=00", i, b1.rsp_valid, b1.rsp_data);
         end
      end
      b1.req_valid = 1'b0;
      tick;
   endtask
   task automatic test_reset_mid_sweep;
      int n;
      b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 6'h01; b1.req_data = 8'h99;
      tick;
      b1.req_we = 1'b0;
      tick;
      b1.req_valid = 1'b0;
      b1.clear = 1'b1;
      tick;
      b1.clear = 1'b0;
      for (int i = 0; i < 30; i++) tick;
      checks++; if (b1.busy !== 1'b1 || b1.rsp_data !== 8'h99) begin fails++; $display("FAIL mid_sweep_hold: got busy=%0b d=%h want busy=1 d=99", b1.busy, b1.rsp_data); end
      rst = 1'b1;
      #1;
      checks++; if (b1.busy !== 1'b1 || b1.req_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ctl: got busy=%0b ready=%0b want 1 0", b1.busy, b1.req_ready); end
      checks++; if (b1.rsp_valid !== 1'b0 || b1.rsp_data !== 8'h00) begin fails++; $display("FAIL mid_rst_rsp: got v=%0b d=%h want v=0 d=00", b1.rsp_valid, b1.rsp_data); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n = 0;
      while (b1.busy && n < 200) begin
         tick;
         n++;
      end
      checks++; if (n != 64) begin fails++; $display("FAIL resweep_len: got %0d cycles want 64", n); end
      b1.req_valid = 1'b1; b1.req_addr = 6'h01;
      tick;
      b1.req_addr = 6'h3F;
      checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 8'h00) begin fails++; $display("FAIL resweep_01: got v=%0b d=%h want v=1 d=00", b1.rsp_valid, b1.rsp_data); end
      tick;
      b1.req_valid = 1'b0;
      checks++; if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== 8'h00) begin fails++; $display("FAIL resweep_3f: got v=%0b d=%h want v=1 d=00", b1.rsp_valid, b1.rsp_data); end
      tick;
   endtask
   task automatic test_lat2;
      int  n;
      bit  bad;
      @(negedge clk);
      rst2 = 1'b0;
      #1;
      n = 0;
      while (b2.busy && n < 200) begin
         tick;
         n++;
      end
      checks++; if (n != 64) begin fails++; $display("FAIL l2_sweep_len: got %0d cycles want 64", n); end
      b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.req_addr = 6'h10;
      tick;
      b2.req_valid = 1'b0;
      checks++; if (b2.rsp_valid !== 1'b0) begin fails++; $display("FAIL l2_early: got v=%0b want 0", b2.rsp_valid); end
      tick;
      checks++; if (b2.rsp_valid !== 1'b1 || b2.rsp_data !== 8'h5A) begin fails++; $display("FAIL l2_clear_val: got v=%0b d=%h want v=1 d=5a", b2.rsp_valid, b2.rsp_data); end
      b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_addr = 6'h05; b2.req_data = 8'h3C;
      tick;
      b2.req_we = 1'b0;
      tick;
      b2.req_valid = 1'b0;
      checks++; if (b2.rsp_valid !== 1'b0) begin fails++; $display("FAIL l2_lat_1: got v=%0b want 0", b2.rsp_valid); end
      tick;
      checks++; if (b2.rsp_valid !== 1'b1 || b2.rsp_data !== 8'h3C) begin fails++; $display("FAIL l2_lat_2: got v=%0b d=%h want v=1 d=3c", b2.rsp_valid, b2.rsp_data); end
      tick;
      checks++; if (b2.rsp_valid !== 1'b0) begin fails++; $display("FAIL l2_lat_3: got v=%0b want 0", b2.rsp_valid); end
      b2.req_valid = 1'b1;
      tick;
      b2.req_valid = 1'b0;
      rst2 = 1'b1;
      #1;
      checks++; if (b2.busy !== 1'b1 || b2.rsp_data !== 8'h00) begin fails++; $display("FAIL l2_rst: got busy=%0b d=%h want busy=1 d=00", b2.busy, b2.rsp_data); end
      @(negedge clk);
      rst2 = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (b2.rsp_valid !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad) begin fails++; $display("FAIL l2_dropped: got rsp_valid=1 after reset want 0"); end
   endtask
   initial begin
      rst = 1'b0; rst2 = 1'b0;
      b1.clear = 1'b0; b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_data = '0;
      b2.clear = 1'b0; b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0; b2.req_data = '0;
      #1;
      rst2 = 1'b1;
      test_reset;
      test_write_read;
      test_back_to_back;
      test_clear;
      test_reset_mid_sweep;
      test_lat2;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
